// File: rtl/count_clk_pkg.sv
// Shared constants and legality helpers for the twelve-hour BCD wall clock.
package count_clk_pkg;

  localparam logic [7:0] HH_RST = 8'h12;
  localparam logic [7:0] MM_RST = 8'h00;
  localparam logic [7:0] SS_RST = 8'h00;
  localparam logic       PM_RST = 1'b0;

  localparam logic [7:0] SEC_MIN_MAX    = 8'h59;
  localparam logic [7:0] HOUR_MAX       = 8'h12;
  localparam logic [7:0] HOUR_MIN       = 8'h01;
  localparam logic [7:0] HOUR_PM_TOGGLE = 8'h11;
  localparam logic [3:0] DIGIT_MAX      = 4'h9;

  function automatic logic legal_mod60(input logic [7:0] v);
    return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= SEC_MIN_MAX[7:4]);
  endfunction

  function automatic logic legal_hour(input logic [7:0] v);
    return (v[3:0] <= DIGIT_MAX) && (v >= HOUR_MIN) && (v <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/count_clk_bcd_mod60.sv
// Two-digit packed-BCD 00-59 counter with enable, carry out and synchronous reset.
module bcd_mod60
  import count_clk_pkg::*;
#(
  parameter logic [7:0] RstVal = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic [7:0] cnt,
  output logic       carry
);

  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    carry = 1'b0;
    if (ena) begin
      if (cnt == SEC_MIN_MAX) begin
        cnt_d = 8'h00;
        carry = 1'b1;
      end else if (cnt[3:0] == DIGIT_MAX) begin
        cnt_d = {cnt[7:4] + 4'd1, 4'h0};
      end else begin
        cnt_d = {cnt[7:4], cnt[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RstVal;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/count_clk.sv
// Twelve-hour BCD wall clock; one enabled cycle is one second.
// Define COUNT_CLK_ILLEGAL_RECOVER_EN to reload 12:00:00 AM from any illegal stored value.
module count_clk
  import count_clk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  logic       sec_carry;
  logic       min_carry;
  logic       recover;
  logic       clr;
  logic [7:0] hh_d;
  logic       pm_d;

`ifdef COUNT_CLK_ILLEGAL_RECOVER_EN
  assign recover = ena & ~(legal_mod60(ss) & legal_mod60(mm) & legal_hour(hh));
`else
  assign recover = 1'b0;
`endif

  // Recovery reuses the synchronous reset path so all fields reload together.
  assign clr = reset | recover;

  bcd_mod60 #(
    .RstVal(SS_RST)
  ) u_ss (
    .clk  (clk),
    .reset(clr),
    .ena  (ena),
    .cnt  (ss),
    .carry(sec_carry)
  );

  bcd_mod60 #(
    .RstVal(MM_RST)
  ) u_mm (
    .clk  (clk),
    .reset(clr),
    .ena  (sec_carry),
    .cnt  (mm),
    .carry(min_carry)
  );

  always_comb begin
    hh_d = hh;
    pm_d = pm;
    if (min_carry) begin
      if (hh == HOUR_MAX) begin
        hh_d = HOUR_MIN;
      end else if (hh[3:0] == DIGIT_MAX) begin
        hh_d = {hh[7:4] + 4'd1, 4'h0};
      end else begin
        hh_d = {hh[7:4], hh[3:0] + 4'd1};
      end
      // Meridiem flips entering 12 o'clock, not on the 12 -> 01 step.
      if (hh == HOUR_PM_TOGGLE) begin
        pm_d = ~pm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hh <= HH_RST;
      pm <= PM_RST;
    end else begin
      hh <= hh_d;
      pm <= pm_d;
    end
  end

endmodule

// File: tb/tb_count_clk.sv
// Directed and model-based checks for the twelve-hour BCD wall clock.
module tb_count_clk;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic [24:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_clk dut (
    .clk  (clk),
    .reset(reset),
    .ena  (ena),
    .pm   (pm),
    .hh   (hh),
    .mm   (mm),
    .ss   (ss)
  );

  assign obs = {pm, hh, mm, ss};

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Seconds-since-midnight to {pm, hh, mm, ss}.
  function automatic logic [24:0] model(input int t);
    int h;
    logic p;
    h = (t / 3600) % 12;
    if (h == 0) h = 12;
    p = (t >= 43200);
    return {p, to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    ena = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    exp = {1'b0, 8'h12, 8'h00, 8'h00};
    reset = 1'b1;
    ena   = 1'b1;
    step();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_ena: got %h expected %h", obs, exp);
    end
    step();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_seconds();
    logic [24:0] exp;
    reset = 1'b0;
    run(1);
    exp = {1'b0, 8'h12, 8'h00, 8'h01};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL first_advance: got %h expected %h", obs, exp);
    end
    run(9);
    exp = {1'b0, 8'h12, 8'h00, 8'h10};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL sec_10: got %h expected %h", obs, exp);
    end
    run(50);
    exp = {1'b0, 8'h12, 8'h01, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL min_carry: got %h expected %h", obs, exp);
    end
    run(3540);
    exp = {1'b0, 8'h01, 8'h00, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hour_12_to_01: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_hold();
    logic [24:0] exp;
    run(8865);
    exp = {1'b0, 8'h03, 8'h27, 8'h45};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reach_032745: got %h expected %h", obs, exp);
    end
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hold_%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_am_pm();
    logic [24:0] exp;
    run(30734);
    exp = {1'b0, 8'h11, 8'h59, 8'h59};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL am_115959: got %h expected %h", obs, exp);
    end
    run(1);
    exp = {1'b1, 8'h12, 8'h00, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL to_pm: got %h expected %h", obs, exp);
    end
    run(3599);
    exp = {1'b1, 8'h12, 8'h59, 8'h59};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pm_125959: got %h expected %h", obs, exp);
    end
    run(1);
    exp = {1'b1, 8'h01, 8'h00, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pm_12_to_01: got %h expected %h", obs, exp);
    end
    run(39599);
    exp = {1'b1, 8'h11, 8'h59, 8'h59};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pm_115959: got %h expected %h", obs, exp);
    end
    run(1);
    exp = {1'b0, 8'h12, 8'h00, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL to_am: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [24:0] exp;
    run(77);
    exp = {1'b0, 8'h12, 8'h01, 8'h17};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pre_reset: got %h expected %h", obs, exp);
    end
    reset = 1'b1;
    ena   = 1'b1;
    step();
    exp = {1'b0, 8'h12, 8'h00, 8'h00};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", obs, exp);
    end
    reset = 1'b0;
    step();
    exp = {1'b0, 8'h12, 8'h00, 8'h01};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL post_reset: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_random();
    int t;
    int enabled;
    int iters;
    logic [24:0] exp;
    reset = 1'b1;
    ena   = 1'b1;
    step();
    reset = 1'b0;
    t = $urandom_range(0, 4000);
    run(t);
    enabled = 0;
    iters   = 0;
    while (enabled < 500 && iters < 2000) begin
      ena = ($urandom_range(0, 3) != 0);
      step();
      if (ena) begin
        t = (t + 1) % 86400;
        enabled++;
      end
      iters++;
      exp = model(t);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_t%0d: got %h expected %h", t, obs, exp);
      end
    end
    n_checks++;
    if (enabled != 500) begin
      n_fail++;
      $display("FAIL random_budget: got %0d enabled edges expected 500", enabled);
    end
  endtask

  initial begin
    reset = 1'b1;
    ena   = 1'b0;
    test_reset();
    test_seconds();
    test_hold();
    test_am_pm();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_clk.md
# count_clk

Twelve-hour wall clock counter keeping hours, minutes and seconds in packed BCD with an AM/PM flag. Each enabled clock cycle is one second. It sits behind a one-pulse-per-second tick generator and drives display/decoder logic directly from its registered outputs.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clock clk. Loads 12:00:00 AM.
- ena  input  1  one-second advance enable, sampled on rising clk.
- pm  output  1  0 = AM, 1 = PM.
- hh  output  8  hours, packed BCD, legal 01–12.
- mm  output  8  minutes, packed BCD, legal 00–59.
- ss  output  8  seconds, packed BCD, legal 00–59.

## Operation
- Reset values: pm=0, hh=8'h12, mm=8'h00, ss=8'h00.
- Reset has priority over ena; reset with ena=1 still loads reset values.
- ena=0, reset=0: all outputs hold.
- ena=1, reset=0: seconds advance by one:
  - ss low digit 0–9; 9 wraps to 0 with carry into high digit; 5-9 (59) wraps to 00 and carries into mm.
  - mm uses same 00–59 rule; 59→00 only when ss wraps, and carries into hh.
  - hh on minute carry: 12→01, 01→02 … 09→10 (BCD digit carry), 10→11, 11→12.
  - pm toggles only on the 11→12 hour step (11:59:59→12:00:00, both AM→PM and PM→AM). 12→01 does not touch pm.
- Full cycle: 86400 enabled cycles return to 12:00:00 AM.
- Outputs never take values outside legal BCD ranges when started from reset.

## Timing
- All outputs are registers updated on rising clk; no combinational path from inputs to outputs.
- Latency one cycle: increment sampled at edge N visible after edge N.
- Reset deasserting at edge N: first advance occurs at edge N+1 if ena=1.
- Ripple carry ss→mm→hh→pm resolves within the same cycle (e.g. 11:59:59 AM → 12:00:00 PM in one edge).
- Reset mid-count: next edge yields reset values regardless of current state.

## Configuration
- COUNT_CLK_ILLEGAL_RECOVER_EN defined: any enabled cycle where a register holds an illegal value (BCD digit >9, ss/mm >59, hh 00 or >12) loads reset values (12:00:00 AM) instead of incrementing; legal operation unchanged.
- Not defined: no legality check; increments apply the rules above to whatever is stored, with no recovery guarantee.

## Structure
- Package count_clk_pkg: reset constants (HH_RST=8'h12, MM_RST=8'h00, SS_RST=8'h00, PM_RST=0), digit limits (SEC_MIN_MAX=8'h59, HOUR_MAX=8'h12, HOUR_MIN=8'h01, HOUR_PM_TOGGLE=8'h11).
- One sub-module bcd_mod60: two-digit BCD 00–59 counter with enable in, carry out, synchronous reset; instantiated for ss and mm. Hours and pm logic inline in count_clk.

## Test plan
- reset=1, ena=1 for one edge -> 0,12,00,00; release reset, 10 enabled edges -> 0,12,00,10.
- Further 50 enabled edges -> 0,12,01,00; further 3540 -> 0,01,00,00 (12→01 with pm unchanged).
- From reset, 43199 enabled edges -> 0,11,59,59; one more -> 1,12,00,00.
- Continue 3599 -> 1,12,59,59; one more -> 1,01,00,00; 39599 more -> 1,11,59,59; one more -> 0,12,00,00.
- ena=0 for 20 edges at 0,03,27,45 -> outputs unchanged; reset asserted mid-count with ena=1 -> 0,12,00,00 next edge.
- Lock-step reference model over 500 random-phase enabled edges after reset -> every cycle exact match of pm,hh,mm,ss.
